// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer tone generator.
// Contents:
//   PERIOD_W        width of the tone period (in ticks)
//   *_DEFAULT       default clock, tick and minimum-period settings
//   tone_state_t    tone FSM state encoding
//   high_len/low_len  split of a period into HIGH and LOW phase lengths
package buzzer_pkg;

   localparam int unsigned PERIOD_W           = 13;
   localparam int unsigned CLK_HZ_DEFAULT     = 100_000_000;
   localparam int unsigned TICK_HZ_DEFAULT    = 1_000_000;
   localparam int unsigned MIN_PERIOD_DEFAULT = 2;

   typedef logic [PERIOD_W-1:0] period_t;

   typedef enum logic [1:0] {
      StIdle,
      StHigh,
      StLow
   } tone_state_t;

   // Odd periods put the extra tick in the HIGH phase.
   function automatic period_t high_len(input period_t p);
      return p - (p >> 1);
   endfunction

   function automatic period_t low_len(input period_t p);
      return p >> 1;
   endfunction

endpackage

// File: rtl/buzzer_tone_gen_if.sv
// Tone request/status bundle between the note sequencer and the tone generator.
// Signals:
//   iPeriodUs   full tone period in ticks, 0 = silence (sequencer -> generator)
//   iEnable     master enable, low mutes immediately   (sequencer -> generator)
//   oBuzzer     square wave for the piezo pin           (generator -> pin/sequencer)
//   oActive     high while a tone is being generated    (generator -> sequencer)
//   oCycleDone  one-clock pulse at each completed period (generator -> sequencer)
// Modports: master = sequencer side, slave = tone generator side.
interface buzzer_tone_gen_if;
   import buzzer_pkg::*;

   period_t iPeriodUs;
   logic    iEnable;
   logic    oBuzzer;
   logic    oActive;
   logic    oCycleDone;

   modport master (
      output iPeriodUs,
      output iEnable,
      input  oBuzzer,
      input  oActive,
      input  oCycleDone
   );

   modport slave (
      input  iPeriodUs,
      input  iEnable,
      output oBuzzer,
      output oActive,
      output oCycleDone
   );

endinterface

// File: rtl/us_tick_gen.sv
// Prescaler producing one tick every DIV clocks.
// Ports:
//   iClk      system clock
//   iReset_n  synchronous active-low reset
//   iClear    synchronous clear; counter restarts from 0 on the next clock
//   oTick     high for the last clock of every DIV-clock window
// DIV = 1 gives a tick on every clock.
module us_tick_gen #(
   parameter int unsigned DIV = 100
) (
   input  logic iClk,
   input  logic iReset_n,
   input  logic iClear,
   output logic oTick
);

   localparam int unsigned     CntW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   assign oTick = (cnt_q == CntMax);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (iClear || oTick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Square-wave tone generator for the piezo buzzer.
// Plays a tone whose full period is tone_io.iPeriodUs ticks (one tick = CLK_HZ/TICK_HZ
// clocks). A new period is only taken at a cycle boundary, so note changes never glitch.
// Ports:
//   iClk      system clock
//   iReset_n  synchronous active-low reset
//   tone_io   slave side of buzzer_tone_gen_if (period/enable in, buzzer/status out)
// Parameters:
//   CLK_HZ      system clock frequency
//   TICK_HZ     tick rate the period is counted in
//   MIN_PERIOD  smallest period played; anything shorter is silence
module buzzer_tone_gen
   import buzzer_pkg::*;
#(
   parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
   parameter int unsigned TICK_HZ    = TICK_HZ_DEFAULT,
   parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
   input  logic               iClk,
   input  logic               iReset_n,
   buzzer_tone_gen_if.slave   tone_io
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;

   if (DIV < 1) begin : gen_div_check
      $error("buzzer_tone_gen: CLK_HZ / TICK_HZ must be at least 1");
   end

   tone_state_t state_q;
   tone_state_t state_d;
   period_t     phase_q;
   period_t     phase_d;
   period_t     period_q;
   period_t     period_d;
   logic        buzzer_q;
   logic        buzzer_d;
   logic        active_q;
   logic        active_d;
   logic        cycle_done_q;
   logic        cycle_done_d;

   logic        tick;
   logic        tick_clear;
   logic        valid;
   logic        cycle_end;
   period_t     high_last;
   period_t     low_last;

   // Holding the prescaler at 0 while idle makes the first phase exactly H*DIV clocks.
   assign tick_clear = (state_q == StIdle);

   us_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .iClk     (iClk),
      .iReset_n (iReset_n),
      .iClear   (tick_clear),
      .oTick    (tick)
   );

   assign valid = tone_io.iEnable && (tone_io.iPeriodUs >= period_t'(MIN_PERIOD));

   // Only meaningful outside IDLE, where the shadow period is at least MIN_PERIOD.
   assign high_last = high_len(period_q) - period_t'(1);
   assign low_last  = low_len(period_q) - period_t'(1);

   // State register
   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         state_q      <= StIdle;
         phase_q      <= '0;
         period_q     <= '0;
         buzzer_q     <= 1'b0;
         active_q     <= 1'b0;
         cycle_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         period_q     <= period_d;
         buzzer_q     <= buzzer_d;
         active_q     <= active_d;
         cycle_done_q <= cycle_done_d;
      end
   end

   // Next state, phase counter and period shadow
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      period_d  = period_q;
      cycle_end = 1'b0;

      if (!tone_io.iEnable) begin
         // Mute wins over any boundary on the same clock, so no cycle-done pulse.
         state_d = StIdle;
         phase_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (valid) begin
                  state_d  = StHigh;
                  period_d = tone_io.iPeriodUs;
                  phase_d  = '0;
               end
            end
            StHigh: begin
               if (tick) begin
                  if (phase_q == high_last) begin
                     state_d = StLow;
                     phase_d = '0;
                  end else begin
                     phase_d = phase_q + period_t'(1);
                  end
               end
            end
            StLow: begin
               if (tick) begin
                  if (phase_q == low_last) begin
                     cycle_end = 1'b1;
                     phase_d   = '0;
                     if (valid) begin
                        // Back-to-back cycle; the period may change only here.
                        state_d  = StHigh;
                        period_d = tone_io.iPeriodUs;
                     end else begin
                        state_d = StIdle;
                     end
                  end else begin
                     phase_d = phase_q + period_t'(1);
                  end
               end
            end
            default: begin
               state_d = StIdle;
               phase_d = '0;
            end
         endcase
      end
   end

   // Registered outputs follow the next state so they line up with state_q.
   always_comb begin
      buzzer_d     = (state_d == StHigh);
      active_d     = (state_d != StIdle);
      cycle_done_d = cycle_end;
   end

   assign tone_io.oBuzzer    = buzzer_q;
   assign tone_io.oActive    = active_q;
   assign tone_io.oCycleDone = cycle_done_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
module tb_buzzer_tone_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n;
   logic rst_b_n;

   buzzer_tone_gen_if a_if ();
   buzzer_tone_gen_if b_if ();

   // DIV = 4
   buzzer_tone_gen #(
      .CLK_HZ     (4),
      .TICK_HZ    (1),
      .MIN_PERIOD (2)
   ) dut_a (
      .iClk     (clk),
      .iReset_n (rst_a_n),
      .tone_io  (a_if)
   );

   // DIV = 1, used for the maximum-period run
   buzzer_tone_gen #(
      .CLK_HZ     (1),
      .TICK_HZ    (1),
      .MIN_PERIOD (2)
   ) dut_b (
      .iClk     (clk),
      .iReset_n (rst_b_n),
      .tone_io  (b_if)
   );

   typedef struct {
      logic        rst_n;
      logic        en;
      logic [12:0] per;
      int          n;
      logic [2:0]  exp;   // {oBuzzer, oActive, oCycleDone}
   } vec_t;

   typedef struct {
      int         row;
      logic [2:0] exp;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];
   sb_t  sb_cur;

   int n_tests = 0;
   int n_fail  = 0;
   int len;

   task automatic add_vec(input logic rst_n, input logic en, input logic [12:0] per,
                          input int n, input logic buz, input logic act, input logic done);
      vec_t v;
      v.rst_n = rst_n;
      v.en    = en;
      v.per   = per;
      v.n     = n;
      v.exp   = {buz, act, done};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int got, input int req);
      n_tests++;
      if (got != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   // Counts consecutive samples (posedge + 1) with oBuzzer of dut_b at lvl.
   task automatic run_len(input logic lvl, input int limit, output int cnt);
      cnt = 0;
      while (b_if.oBuzzer === lvl && cnt < limit) begin
         cnt++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_a_n        = 1'b0;
      a_if.iEnable   = 1'b0;
      a_if.iPeriodUs = '0;
      rst_b_n        = 1'b0;
      b_if.iEnable   = 1'b0;
      b_if.iPeriodUs = '0;

      // rst_n, en, period, clocks, expected buzzer/active/cycle-done after each edge
      add_vec(0, 0, 0, 3, 0, 0, 0);    // reset
      add_vec(1, 1, 5, 12, 1, 0 + 1, 0); // P=5: 3 ticks high
      add_vec(1, 1, 5, 8, 0, 1, 0);    // 2 ticks low
      add_vec(1, 1, 5, 1, 1, 1, 1);    // boundary, back-to-back
      add_vec(1, 1, 5, 11, 1, 1, 0);
      add_vec(1, 1, 5, 8, 0, 1, 0);
      add_vec(1, 1, 5, 1, 1, 1, 1);
      add_vec(1, 1, 8, 11, 1, 1, 0);   // change to 8 mid-HIGH: ignored this cycle
      add_vec(1, 1, 8, 8, 0, 1, 0);
      add_vec(1, 1, 8, 1, 1, 1, 1);    // P=8 loaded at boundary
      add_vec(1, 1, 8, 15, 1, 1, 0);
      add_vec(1, 1, 8, 16, 0, 1, 0);
      add_vec(1, 1, 8, 1, 1, 1, 1);
      add_vec(1, 1, 8, 15, 1, 1, 0);
      add_vec(1, 1, 8, 5, 0, 1, 0);
      add_vec(1, 1, 0, 11, 0, 1, 0);   // silence mid-LOW: cycle completes
      add_vec(1, 1, 0, 1, 0, 0, 1);    // final cycle-done, back to idle
      add_vec(1, 1, 0, 4, 0, 0, 0);
      add_vec(1, 1, 1, 6, 0, 0, 0);    // period 1 below minimum
      add_vec(1, 1, 5, 1, 1, 1, 0);    // start from idle: no cycle-done
      add_vec(1, 1, 5, 5, 1, 1, 0);
      add_vec(1, 0, 5, 1, 0, 0, 0);    // mute mid-HIGH
      add_vec(1, 0, 5, 3, 0, 0, 0);
      add_vec(1, 1, 5, 12, 1, 1, 0);   // re-enable: full HIGH
      add_vec(1, 1, 5, 8, 0, 1, 0);
      add_vec(1, 1, 5, 1, 1, 1, 1);
      add_vec(1, 1, 5, 4, 1, 1, 0);
      add_vec(0, 1, 5, 1, 0, 0, 0);    // reset mid-tone
      add_vec(0, 1, 5, 2, 0, 0, 0);
      add_vec(1, 1, 5, 12, 1, 1, 0);   // clean restart
      add_vec(1, 1, 5, 8, 0, 1, 0);
      add_vec(1, 1, 5, 1, 1, 1, 1);
      add_vec(1, 1, 5, 11, 1, 1, 0);
      add_vec(1, 1, 5, 8, 0, 1, 0);
      add_vec(1, 0, 5, 1, 0, 0, 0);    // mute on the boundary edge: no pulse
      add_vec(1, 0, 0, 2, 0, 0, 0);
      add_vec(1, 1, 2, 4, 1, 1, 0);    // minimum period
      add_vec(1, 1, 2, 4, 0, 1, 0);
      add_vec(1, 1, 2, 1, 1, 1, 1);
      add_vec(1, 1, 2, 3, 1, 1, 0);
      add_vec(1, 1, 3, 4, 0, 1, 0);    // change to odd period mid-LOW
      add_vec(1, 1, 3, 1, 1, 1, 1);    // P=3: H=2 ticks, L=1 tick
      add_vec(1, 1, 3, 7, 1, 1, 0);
      add_vec(1, 1, 3, 4, 0, 1, 0);
      add_vec(1, 1, 0, 1, 0, 0, 1);
      add_vec(1, 1, 0, 2, 0, 0, 0);

      foreach (vecs[r]) begin
         for (int k = 0; k < vecs[r].n; k++) begin
            rst_a_n        = vecs[r].rst_n;
            a_if.iEnable   = vecs[r].en;
            a_if.iPeriodUs = vecs[r].per;
            sb_cur.row     = r;
            sb_cur.exp     = vecs[r].exp;
            sb_q.push_back(sb_cur);
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
               sb_cur = sb_q.pop_front();
               check($sformatf("vec row %0d step %0d {buz,act,done}", sb_cur.row, k),
                     int'({a_if.oBuzzer, a_if.oActive, a_if.oCycleDone}), int'(sb_cur.exp));
            end
            #1;
         end
      end
      check("scoreboard drained", sb_q.size(), 0);

      // Maximum period with a tick every clock: 4096 high / 4095 low, held period.
      @(posedge clk);
      #1;
      check("b reset outputs", int'({b_if.oBuzzer, b_if.oActive, b_if.oCycleDone}), 0);
      #1;
      rst_b_n        = 1'b1;
      b_if.iEnable   = 1'b1;
      b_if.iPeriodUs = 13'd8191;
      @(posedge clk);
      #1;
      check("b first high", int'(b_if.oBuzzer), 1);
      check("b first no done", int'(b_if.oCycleDone), 0);
      run_len(1'b1, 10000, len);
      check("b max high len", len, 4096);
      check("b active in low", int'(b_if.oActive), 1);
      run_len(1'b0, 10000, len);
      check("b max low len", len, 4095);
      check("b boundary done", int'(b_if.oCycleDone), 1);
      run_len(1'b1, 10000, len);
      check("b held high len", len, 4096);
      check("b done single clock", int'(b_if.oCycleDone), 0);
      #1;
      b_if.iEnable = 1'b0;
      @(posedge clk);
      #1;
      check("b mute active", int'(b_if.oActive), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
